// File: rtl/ibex_pkg.sv
// Shared definitions for the CSR read-modify-write sequencer.
package ibex_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'd0,
    CSR_OP_WRITE = 2'd1,
    CSR_OP_SET   = 2'd2,
    CSR_OP_CLEAR = 2'd3
  } csr_rmw_op_e;

endpackage

// File: rtl/ibex_csr_rmw_chk.sv
// Protocol checks for ibex_csr_rmw, attached to every instance through bind.
module ibex_csr_rmw_chk #(
  parameter int unsigned NumCsr = 4
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic              req_valid_i,
  input logic              resp_ready_i,
  input logic [NumCsr-1:0] csr_wr_en_o
);

  a_inputs_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({req_valid_i, resp_ready_i}));

  a_wr_en_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown(csr_wr_en_o));

  a_wr_en_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(csr_wr_en_o));

endmodule

bind ibex_csr_rmw ibex_csr_rmw_chk #(.NumCsr(NumCsr)) u_chk (
  .clk_i        (clk_i),
  .rst_ni       (rst_ni),
  .req_valid_i  (req_valid_i),
  .resp_ready_i (resp_ready_i),
  .csr_wr_en_o  (csr_wr_en_o)
);

// File: rtl/ibex_csr_rmw.sv
// Serialises READ/WRITE/SET/CLEAR requests onto a bank of external CSR primitives,
// reporting the pre-operation value and flagging shadow-register integrity errors.
module ibex_csr_rmw
  import ibex_pkg::*;
#(
  parameter int unsigned Width  = 32,
  parameter int unsigned NumCsr = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [1:0]                req_op_i,
  input  logic [$clog2(NumCsr)-1:0] req_idx_i,
  input  logic [Width-1:0]          req_wdata_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [Width-1:0]          resp_rdata_o,
  output logic                      resp_error_o,
  output logic [NumCsr-1:0]         csr_wr_en_o,
  output logic [Width-1:0]          csr_wr_data_o,
  input  logic [NumCsr*Width-1:0]   csr_rd_data_i,
  input  logic [NumCsr-1:0]         csr_rd_error_i,
  output logic                      alert_o
);

  localparam int unsigned IdxW = $clog2(NumCsr);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StResp  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  csr_rmw_op_e         op_q, op_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [Width-1:0]    wdata_q, wdata_d;
  logic [Width-1:0]    old_q, old_d;
  logic                err_q, err_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [NumCsr-1:0]   wr_en_q, wr_en_d;
  logic [Width-1:0]    wr_data_q, wr_data_d;
  logic                alert_q, alert_d;

  logic [Width-1:0]    rd_val_s;
  logic                rd_err_s;
  logic                hit_s;
  logic [Width-1:0]    new_s;
  logic                do_write_s;

  // Select the addressed CSR; an index with no primitive behind it reads as zero, no flag.
  always_comb begin
    rd_val_s = {Width{1'b0}};
    rd_err_s = 1'b0;
    hit_s    = 1'b0;
    for (int unsigned k = 0; k < NumCsr; k++) begin
      rd_val_s = (idx_q == IdxW'(k)) ? csr_rd_data_i[k*Width +: Width] : rd_val_s;
      rd_err_s = (idx_q == IdxW'(k)) ? csr_rd_error_i[k] : rd_err_s;
      hit_s    = hit_s | (idx_q == IdxW'(k));
    end
  end

  // New CSR value and whether the operation actually needs a write cycle.
  always_comb begin
    case (op_q)
      CSR_OP_WRITE: new_s = wdata_q;
      CSR_OP_SET:   new_s = rd_val_s | wdata_q;
      CSR_OP_CLEAR: new_s = rd_val_s & ~wdata_q;
      default:      new_s = rd_val_s;
    endcase
    do_write_s = hit_s && !rd_err_s &&
                 ((op_q == CSR_OP_WRITE) ||
                  (((op_q == CSR_OP_SET) || (op_q == CSR_OP_CLEAR)) && (wdata_q != {Width{1'b0}})));
  end

  // Next-state and registered-output computation for the request sequencer.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    old_d        = old_q;
    err_d        = err_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    wr_en_d      = {NumCsr{1'b0}};
    wr_data_d    = wr_data_q;
    alert_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_q) begin
          op_d    = csr_rmw_op_e'(req_op_i);
          idx_d   = req_idx_i;
          wdata_d = req_wdata_i;
          state_d = StRead;
        end else begin
          req_ready_d = 1'b1;
        end
      end
      StRead: begin
        old_d   = rd_val_s;
        err_d   = !hit_s || rd_err_s;
        alert_d = hit_s && rd_err_s;
        if (do_write_s) begin
          wr_en_d   = {{(NumCsr-1){1'b0}}, 1'b1} << idx_q;
          wr_data_d = new_s;
          state_d   = StWrite;
        end else begin
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
      end
      StWrite: begin
        resp_valid_d = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (resp_ready_i) begin
          req_ready_d = 1'b1;
          state_d     = StIdle;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      op_q         <= CSR_OP_READ;
      idx_q        <= {IdxW{1'b0}};
      wdata_q      <= {Width{1'b0}};
      old_q        <= {Width{1'b0}};
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      wr_en_q      <= {NumCsr{1'b0}};
      wr_data_q    <= {Width{1'b0}};
      alert_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      alert_q      <= alert_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign resp_valid_o  = resp_valid_q;
  assign resp_rdata_o  = old_q;
  assign resp_error_o  = err_q;
  assign csr_wr_en_o   = wr_en_q;
  assign csr_wr_data_o = wr_data_q;
  assign alert_o       = alert_q;

endmodule

// File: tb/tb_ibex_csr_rmw.sv
// Bench for ibex_csr_rmw with three CSRs (index 3 is out of range): directed table,
// reset corner cases and randomized requests against a reference model.
module tb_ibex_csr_rmw;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = 2'd0;
  logic [1:0]  req_idx_i = 2'd0;
  logic [31:0] req_wdata_i = 32'd0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_error_o;
  logic [2:0]  csr_wr_en_o;
  logic [31:0] csr_wr_data_o;
  logic [95:0] csr_rd_data_i;
  logic [2:0]  csr_rd_error_i = 3'b000;
  logic        alert_o;

  logic [31:0] mem [3];
  logic [31:0] model_mem [3];
  int          checks = 0;
  int          errors = 0;

  ibex_csr_rmw #(.Width(32), .NumCsr(3)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_op_i       (req_op_i),
    .req_idx_i      (req_idx_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_ready_i   (resp_ready_i),
    .resp_rdata_o   (resp_rdata_o),
    .resp_error_o   (resp_error_o),
    .csr_wr_en_o    (csr_wr_en_o),
    .csr_wr_data_o  (csr_wr_data_o),
    .csr_rd_data_i  (csr_rd_data_i),
    .csr_rd_error_i (csr_rd_error_i),
    .alert_o        (alert_o)
  );

  always #5 clk = ~clk;

  // External CSR primitives: reload fixed values while in reset, take DUT write pulses.
  always @(posedge clk) begin
    if (!rst_ni) begin
      mem[0] <= 32'h1234_5678;
      mem[1] <= 32'h0000_00F0;
      mem[2] <= 32'hA5A5_0000;
    end else begin
      for (int k = 0; k < 3; k++)
        if (csr_wr_en_o[k]) mem[k] <= csr_wr_data_o;
    end
  end
  assign csr_rd_data_i = {mem[2], mem[1], mem[0]};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic xact(input int id, input logic [1:0] op, input logic [1:0] idx,
                      input logic [31:0] wd, input logic [2:0] rde, input int stall,
                      input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                      input logic [2:0] e_wren, input logic [31:0] e_wdata, input logic e_alert);
    int          n, lat, wr_pulses, alerts;
    logic [2:0]  seen_en;
    logic [31:0] seen_data, hold_rdata;
    logic        hold_err, busy_ok, stable, done;
    csr_rd_error_i = rde;
    n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("req_ready[%0d]", id), {63'd0, req_ready_o}, 64'd1);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_idx_i   = idx;
    req_wdata_i = wd;
    @(negedge clk);
    req_valid_i = 1'b0;
    lat = 1; wr_pulses = 0; alerts = 0; seen_en = 3'b000; seen_data = 32'd0;
    busy_ok = 1'b1; done = 1'b0;
    while (!done) begin
      if (csr_wr_en_o != 3'b000) begin
        wr_pulses++;
        seen_en   = csr_wr_en_o;
        seen_data = csr_wr_data_o;
      end
      if (alert_o) alerts++;
      if (req_ready_o) busy_ok = 1'b0;
      if (resp_valid_o || lat >= 8) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    chk($sformatf("latency[%0d]", id), 64'(lat), 64'(e_lat));
    chk($sformatf("resp_valid[%0d]", id), {63'd0, resp_valid_o}, 64'd1);
    chk($sformatf("rdata[%0d]", id), {32'd0, resp_rdata_o}, {32'd0, e_rdata});
    chk($sformatf("error[%0d]", id), {63'd0, resp_error_o}, {63'd0, e_err});
    hold_rdata = resp_rdata_o;
    hold_err   = resp_error_o;
    stable     = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      if (csr_wr_en_o != 3'b000) wr_pulses++;
      if (alert_o) alerts++;
      if (!resp_valid_o || resp_rdata_o != hold_rdata || resp_error_o != hold_err || req_ready_o)
        stable = 1'b0;
    end
    chk($sformatf("resp_stable[%0d]", id), {63'd0, stable}, 64'd1);
    resp_ready_i = 1'b1;
    @(negedge clk);
    resp_ready_i = 1'b0;
    chk($sformatf("ready_after_resp[%0d]", id), {62'd0, req_ready_o, resp_valid_o}, 64'd2);
    chk($sformatf("busy_not_ready[%0d]", id), {63'd0, busy_ok}, 64'd1);
    chk($sformatf("wr_pulses[%0d]", id), 64'(wr_pulses), (e_wren != 3'b000) ? 64'd1 : 64'd0);
    if (e_wren != 3'b000) begin
      chk($sformatf("wr_en[%0d]", id), {61'd0, seen_en}, {61'd0, e_wren});
      chk($sformatf("wr_data[%0d]", id), {32'd0, seen_data}, {32'd0, e_wdata});
    end
    chk($sformatf("alert_pulses[%0d]", id), 64'(alerts), {63'd0, e_alert});
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  idx;
    logic [31:0] wd;
    logic [2:0]  rde;
    int          stall;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [2:0]  wren;
    logic [31:0] wdata;
    logic        alert;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // op: 0 READ, 1 WRITE, 2 SET, 3 CLEAR
    tbl[0]  = '{2'd2, 2'd1, 32'h0000_000F, 3'b000, 0, 32'h0000_00F0, 1'b0, 3, 3'b010, 32'h0000_00FF, 1'b0};
    tbl[1]  = '{2'd3, 2'd2, 32'h0000_0000, 3'b000, 0, 32'hA5A5_0000, 1'b0, 2, 3'b000, 32'h0,         1'b0};
    tbl[2]  = '{2'd1, 2'd0, 32'hDEAD_BEEF, 3'b001, 0, 32'h1234_5678, 1'b1, 2, 3'b000, 32'h0,         1'b1};
    tbl[3]  = '{2'd0, 2'd3, 32'h0000_0000, 3'b111, 0, 32'h0000_0000, 1'b1, 2, 3'b000, 32'h0,         1'b0};
    tbl[4]  = '{2'd0, 2'd1, 32'h0000_0000, 3'b000, 5, 32'h0000_00FF, 1'b0, 2, 3'b000, 32'h0,         1'b0};
    tbl[5]  = '{2'd1, 2'd2, 32'hCAFE_F00D, 3'b000, 0, 32'hA5A5_0000, 1'b0, 3, 3'b100, 32'hCAFE_F00D, 1'b0};
    tbl[6]  = '{2'd3, 2'd2, 32'h0000_F00D, 3'b000, 1, 32'hCAFE_F00D, 1'b0, 3, 3'b100, 32'hCAFE_0000, 1'b0};
    tbl[7]  = '{2'd2, 2'd0, 32'h0000_0000, 3'b000, 0, 32'h1234_5678, 1'b0, 2, 3'b000, 32'h0,         1'b0};
    tbl[8]  = '{2'd0, 2'd2, 32'hFFFF_FFFF, 3'b000, 2, 32'hCAFE_0000, 1'b0, 2, 3'b000, 32'h0,         1'b0};
    tbl[9]  = '{2'd1, 2'd1, 32'h0000_0000, 3'b000, 0, 32'h0000_00FF, 1'b0, 3, 3'b010, 32'h0000_0000, 1'b0};
    tbl[10] = '{2'd0, 2'd1, 32'h0000_0000, 3'b000, 0, 32'h0000_0000, 1'b0, 2, 3'b000, 32'h0,         1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {25'd0, req_ready_o, resp_valid_o, resp_error_o, alert_o, csr_wr_en_o},
        64'd0);
    chk("reset_data", {resp_rdata_o, csr_wr_data_o}, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {63'd0, req_ready_o}, 64'd1);

    for (int i = 0; i < 11; i++)
      xact(i, tbl[i].op, tbl[i].idx, tbl[i].wd, tbl[i].rde, tbl[i].stall, tbl[i].rdata,
           tbl[i].err, tbl[i].lat, tbl[i].wren, tbl[i].wdata, tbl[i].alert);

    // Reset while a write-bound request sits in READ.
    csr_rd_error_i = 3'b000;
    req_valid_i = 1'b1; req_op_i = 2'd1; req_idx_i = 2'd0; req_wdata_i = 32'h0000_0055;
    @(negedge clk);
    req_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("midop_reset_outputs",
        {25'd0, req_ready_o, resp_valid_o, resp_error_o, alert_o, csr_wr_en_o}, 64'd0);
    chk("midop_reset_data", {resp_rdata_o, csr_wr_data_o}, 64'd0);
    @(negedge clk);
    chk("midop_reset_hold", {59'd0, req_ready_o, resp_valid_o, csr_wr_en_o}, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("midop_release", {59'd0, req_ready_o, resp_valid_o, csr_wr_en_o}, 64'h10);
    @(negedge clk);
    chk("midop_no_resp", {59'd0, req_ready_o, resp_valid_o, csr_wr_en_o}, 64'h10);

    // Randomized requests against a value-level model of the CSR bank.
    model_mem[0] = 32'h1234_5678;
    model_mem[1] = 32'h0000_00F0;
    model_mem[2] = 32'hA5A5_0000;
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op, idx;
      logic [31:0] wd, old, nv;
      logic [2:0]  rde;
      logic        in_r, e_err, e_alert, writes;
      op  = 2'($urandom_range(0, 3));
      idx = 2'($urandom_range(0, 3));
      wd  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rde = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      in_r    = (idx < 2'd3);
      old     = in_r ? model_mem[idx] : 32'd0;
      e_alert = in_r ? rde[idx] : 1'b0;
      e_err   = !in_r || e_alert;
      writes  = !e_err && (op == 2'd1 || (op >= 2'd2 && wd != 32'd0));
      nv      = (op == 2'd1) ? wd : (op == 2'd2) ? (old | wd) : (old & ~wd);
      xact(100 + i, op, idx, wd, rde, $urandom_range(0, 3), old, e_err, writes ? 3 : 2,
           writes ? (3'b001 << idx) : 3'b000, nv, e_alert);
      if (writes) model_mem[idx] = nv;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
